// File: rtl/kbd_pkg.sv
// Shared types and constants for the CPC keyboard event controller.
// The matrix is 10 rows x 8 bits, positive logic (1 = key down).
package kbd_pkg;

   localparam int NUM_KEYS = 80;
   localparam int NUM_ROWS = 10;

   localparam logic [3:0] DEF_CTRL_ADDR   = 4'hA;
   localparam logic [7:0] DEF_COMMIT_CODE = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_COMMIT,
      ST_HOST
   } kbd_state_e;

   typedef struct packed {
      logic [6:0] key;
      logic       down;
   } kbd_evt_t;

   // Key index 0..79 maps to row key[6:3] and bit key[2:0].
   function automatic logic [3:0] key_row(input logic [6:0] key);
      return key[6:3];
   endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO for the keyboard controller.
// FIFO_DEPTH must be a power of two (pointers wrap naturally).
module kbd_evt_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = 8
) (
   input  logic                          busclk_i,
   input  logic                          nreset_i,
   input  logic                          push,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    cnt;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (cnt == (PTR_W+1)'(FIFO_DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];
   assign count   = cnt;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge busclk_i) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge busclk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/keyboard_event_ctrl.sv
// Keyboard event controller: queues PS/2 make/break events, turns each into
// a read-modify-write of one keyboard row plus a commit write, and shares
// the keyboard register bus with direct host accesses.
// Optional build macro KBD_BATCH_COMMIT_EN: commit only once the event queue
// drains, so a chord reaches the matrix atomically.
module keyboard_event_ctrl
   import kbd_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 8,
   parameter logic [3:0] CTRL_ADDR   = DEF_CTRL_ADDR,
   parameter logic [7:0] COMMIT_CODE = DEF_COMMIT_CODE
) (
   input  logic       busclk_i,
   input  logic       nreset_i,
   input  logic       evt_valid_i,
   input  logic [6:0] evt_key_i,
   input  logic       evt_down_i,
   output logic       evt_ready_o,
   output logic       drop_o,
   input  logic       host_req_i,
   output logic       host_gnt_o,
   input  logic [3:0] host_A_i,
   input  logic [7:0] host_D_i,
   input  logic       host_nWR_i,
   input  logic       host_nRD_i,
   output logic [7:0] host_D_o,
   output logic [3:0] kb_A_o,
   output logic [7:0] kb_D_o,
   output logic       kb_nWR_o,
   output logic       kb_nRD_o,
   input  logic [7:0] kb_D_i,
   output logic       busy_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Set or clear one bit of a row byte according to make/break.
   function automatic logic [7:0] apply_key(input logic [7:0] row_data,
                                            input logic [2:0] bit_idx,
                                            input logic       down);
      logic [7:0] r;
      r          = row_data;
      r[bit_idx] = down;
      return r;
   endfunction

   kbd_state_e       state_q, state_d;
   kbd_evt_t         evt_q, evt_d;
   kbd_evt_t         fifo_head;
   logic [7:0]       fifo_rd_data;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] cnt_next;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic             key_ok;
   logic             evt_take;

   logic             ready_q;
   logic             drop_q;
   logic             fair_q, fair_d;
   logic [3:0]       kb_a_q, kb_a_d;
   logic [7:0]       kb_d_q, kb_d_d;
   logic             kb_nwr_q, kb_nwr_d;
   logic             kb_nrd_q, kb_nrd_d;

   assign key_ok    = (evt_key_i < 7'(NUM_KEYS));
   assign evt_take  = evt_valid_i && ready_q;
   assign fifo_push = evt_take && key_ok;
   assign fifo_head = kbd_evt_t'(fifo_rd_data);

   // Ready is registered from the post-update occupancy, so a pop while
   // full only reopens the queue on the following cycle.
   assign cnt_next  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   kbd_evt_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (8)
   ) u_fifo (
      .busclk_i (busclk_i),
      .nreset_i (nreset_i),
      .push     (fifo_push),
      .wr_data  ({evt_key_i, evt_down_i}),
      .pop      (fifo_pop),
      .rd_data  (fifo_rd_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Event intake handshake and out-of-range drop pulse.
   always_ff @(posedge busclk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         ready_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         ready_q <= (cnt_next != CNT_W'(FIFO_DEPTH));
         drop_q  <= evt_take && !key_ok;
      end
   end

   // Sequencer state, fairness flag and registered keyboard bus.
   always_ff @(posedge busclk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q  <= ST_IDLE;
         fair_q   <= 1'b0;
         kb_a_q   <= '0;
         kb_d_q   <= '0;
         kb_nwr_q <= 1'b1;
         kb_nrd_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         fair_q   <= fair_d;
         kb_a_q   <= kb_a_d;
         kb_d_q   <= kb_d_d;
         kb_nwr_q <= kb_nwr_d;
         kb_nrd_q <= kb_nrd_d;
      end
   end

   // Event being serviced; only meaningful between pop and commit.
   always_ff @(posedge busclk_i) begin
      evt_q <= evt_d;
   end

   // Next-state and next keyboard bus values; strobes idle high by default.
   always_comb begin
      state_d  = state_q;
      fair_d   = fair_q;
      evt_d    = evt_q;
      kb_a_d   = kb_a_q;
      kb_d_d   = kb_d_q;
      kb_nwr_d = 1'b1;
      kb_nrd_d = 1'b1;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (host_req_i && !fair_q) begin
               state_d = ST_HOST;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               evt_d    = fifo_head;
               kb_a_d   = key_row(fifo_head.key);
               kb_nrd_d = 1'b0;
               state_d  = ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            kb_a_d   = key_row(evt_q.key);
            kb_d_d   = apply_key(kb_D_i, evt_q.key[2:0], evt_q.down);
            kb_nwr_d = 1'b0;
            state_d  = ST_WR;
         end
         ST_WR: begin
`ifdef KBD_BATCH_COMMIT_EN
            if (fifo_empty) begin
               kb_a_d   = CTRL_ADDR;
               kb_d_d   = COMMIT_CODE;
               kb_nwr_d = 1'b0;
               state_d  = ST_COMMIT;
            end else begin
               state_d  = ST_IDLE;
            end
`else
            kb_a_d   = CTRL_ADDR;
            kb_d_d   = COMMIT_CODE;
            kb_nwr_d = 1'b0;
            state_d  = ST_COMMIT;
`endif
         end
         ST_COMMIT: begin
            fair_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_HOST: begin
            if (!host_req_i) begin
               state_d = ST_IDLE;
               if (!fifo_empty) fair_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign host_gnt_o = (state_q == ST_HOST) && host_req_i;

   // Host owns the bus combinationally while granted; otherwise registered.
   always_comb begin
      kb_A_o   = kb_a_q;
      kb_D_o   = kb_d_q;
      kb_nWR_o = kb_nwr_q;
      kb_nRD_o = kb_nrd_q;
      if (host_gnt_o) begin
         kb_A_o   = host_A_i;
         kb_D_o   = host_D_i;
         kb_nWR_o = host_nWR_i;
         kb_nRD_o = host_nRD_i;
      end
   end

   assign host_D_o    = kb_D_i;
   assign evt_ready_o = ready_q;
   assign drop_o      = drop_q;
   assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_keyboard_event_ctrl.sv
// Scoreboard bench for keyboard_event_ctrl with a small keyboard-register model.
module tb_keyboard_event_ctrl;

   logic       busclk_i    = 1'b0;
   logic       nreset_i    = 1'b0;
   logic       evt_valid_i = 1'b0;
   logic [6:0] evt_key_i   = '0;
   logic       evt_down_i  = 1'b0;
   logic       evt_ready_o;
   logic       drop_o;
   logic       host_req_i  = 1'b0;
   logic       host_gnt_o;
   logic [3:0] host_A_i    = '0;
   logic [7:0] host_D_i    = '0;
   logic       host_nWR_i  = 1'b1;
   logic       host_nRD_i  = 1'b1;
   logic [7:0] host_D_o;
   logic [3:0] kb_A_o;
   logic [7:0] kb_D_o;
   logic       kb_nWR_o;
   logic       kb_nRD_o;
   logic [7:0] kb_D_i      = '0;
   logic       busy_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [13:0] exp_q [$];

   logic [7:0] kbmem [10] = '{8'h00, 8'h00, 8'h00, 8'h5A, 8'h00,
                              8'h10, 8'h00, 8'h00, 8'h00, 8'hFF};
   logic [7:0] chord_exp [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                                 8'h3F, 8'h7F, 8'hFF, 8'h01};

   keyboard_event_ctrl dut (
      .busclk_i    (busclk_i),
      .nreset_i    (nreset_i),
      .evt_valid_i (evt_valid_i),
      .evt_key_i   (evt_key_i),
      .evt_down_i  (evt_down_i),
      .evt_ready_o (evt_ready_o),
      .drop_o      (drop_o),
      .host_req_i  (host_req_i),
      .host_gnt_o  (host_gnt_o),
      .host_A_i    (host_A_i),
      .host_D_i    (host_D_i),
      .host_nWR_i  (host_nWR_i),
      .host_nRD_i  (host_nRD_i),
      .host_D_o    (host_D_o),
      .kb_A_o      (kb_A_o),
      .kb_D_o      (kb_D_o),
      .kb_nWR_o    (kb_nWR_o),
      .kb_nRD_o    (kb_nRD_o),
      .kb_D_i      (kb_D_i),
      .busy_o      (busy_o)
   );

   always #5 busclk_i = ~busclk_i;

   // Keyboard register bank: read data appears the cycle after the strobe.
   always @(posedge busclk_i) begin
      if (!kb_nRD_o) kb_D_i <= (kb_A_o < 4'd10) ? kbmem[kb_A_o] : 8'h00;
      if (!kb_nWR_o && kb_A_o < 4'd10) kbmem[kb_A_o] <= kb_D_o;
   end

   function automatic logic [13:0] rd_t(input logic [3:0] a);
      return {1'b1, 1'b0, a, 8'h00};
   endfunction

   function automatic logic [13:0] wr_t(input logic [3:0] a, input logic [7:0] d);
      return {1'b0, 1'b1, a, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_evt_exp(input logic [3:0] row, input logic [7:0] wdata);
      exp_q.push_back(rd_t(row));
      exp_q.push_back(wr_t(row, wdata));
      exp_q.push_back(wr_t(4'hA, 8'h01));
   endtask

   // Offer one event and hold it until accepted (bounded).
   task automatic send_evt(input logic [6:0] key, input logic down);
      int n;
      n = 0;
      evt_valid_i = 1'b1;
      evt_key_i   = key;
      evt_down_i  = down;
      while (!evt_ready_o && n < 200) begin
         @(posedge busclk_i); #1;
         n++;
      end
      if (n >= 200) check("evt_accept_timeout", 32'd1, 32'd0);
      @(posedge busclk_i); #1;
      evt_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((busy_o || exp_q.size() != 0) && n < 300) begin
         @(posedge busclk_i); #1;
         n++;
      end
      check({name, "_busy"}, busy_o, 1'b0);
      check({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic wait_gnt(input string name);
      int n;
      n = 0;
      while (!host_gnt_o && n < 50) begin
         @(negedge busclk_i);
         n++;
      end
      check(name, host_gnt_o, 1'b1);
   endtask

   // Monitor: every strobed keyboard bus cycle is popped and compared.
   always @(negedge busclk_i) begin
      logic [13:0] obs;
      logic [13:0] e;
      if (!kb_nWR_o || !kb_nRD_o) begin
         obs = {kb_nWR_o, kb_nRD_o, kb_A_o, kb_nWR_o ? 8'h00 : kb_D_o};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL kb_bus: got unexpected cycle %h, expected none", obs);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
               n_fail++;
               $display("FAIL kb_bus: got %h, expected %h", obs, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge busclk_i);
      #1;
      check("rst_kb_A", kb_A_o, 4'h0);
      check("rst_kb_D", kb_D_o, 8'h00);
      check("rst_kb_nWR", kb_nWR_o, 1'b1);
      check("rst_kb_nRD", kb_nRD_o, 1'b1);
      check("rst_gnt", host_gnt_o, 1'b0);
      check("rst_drop", drop_o, 1'b0);
      check("rst_ready", evt_ready_o, 1'b0);
      nreset_i = 1'b1;
      @(posedge busclk_i); #1;
      check("ready_after_rst", evt_ready_o, 1'b1);

      // Make key 18 on empty row 2
      push_evt_exp(4'd2, 8'h04);
      send_evt(7'd18, 1'b1);
      check("t1_busy_pushed", busy_o, 1'b1);
      repeat (4) @(posedge busclk_i);
      #1;
      check("t1_busy_commit", busy_o, 1'b1);
      @(posedge busclk_i); #1;
      check("t1_busy_done", busy_o, 1'b0);
      check("t1_sb_empty", exp_q.size(), 0);

      // Out-of-range key is dropped
      send_evt(7'd80, 1'b1);
      check("drop_pulse", drop_o, 1'b1);
      @(posedge busclk_i); #1;
      check("drop_one_cycle", drop_o, 1'b0);
      check("drop_not_queued", busy_o, 1'b0);

      // Break key 79 on full row 9
      push_evt_exp(4'd9, 8'h7F);
      send_evt(7'd79, 1'b0);
      wait_drain("t2");

      // Host request during WR is held off until after the commit
      push_evt_exp(4'd5, 8'h11);
      send_evt(7'd40, 1'b1);
      begin
         int n;
         n = 0;
         while (kb_nWR_o && n < 20) begin
            @(negedge busclk_i);
            n++;
         end
      end
      check("t3_wr_row", kb_A_o, 4'd5);
      host_req_i = 1'b1;
      @(negedge busclk_i);
      check("t3_no_gnt_commit", host_gnt_o, 1'b0);
      check("t3_commit_addr", kb_A_o, 4'hA);
      @(negedge busclk_i);
      check("t3_no_gnt_idle", host_gnt_o, 1'b0);
      wait_gnt("t3_gnt");
      check("t3_sb_empty_at_gnt", exp_q.size(), 0);
      @(posedge busclk_i); #1;
      exp_q.push_back(rd_t(4'd3));
      host_A_i   = 4'd3;
      host_nRD_i = 1'b0;
      @(posedge busclk_i); #1;
      host_nRD_i = 1'b1;
      check("t3_host_rd", host_D_o, 8'h5A);
      exp_q.push_back(wr_t(4'd3, 8'hC3));
      host_D_i   = 8'hC3;
      host_nWR_i = 1'b0;
      @(posedge busclk_i); #1;
      host_nWR_i = 1'b1;
      exp_q.push_back(rd_t(4'd3));
      host_nRD_i = 1'b0;
      @(posedge busclk_i); #1;
      host_nRD_i = 1'b1;
      check("t3_host_rd_back", host_D_o, 8'hC3);
      host_req_i = 1'b0;
      #1;
      check("t3_gnt_release", host_gnt_o, 1'b0);
      check("t3_strobe_release", kb_nWR_o, 1'b1);
      @(posedge busclk_i); #1;
      host_nWR_i = 1'b0;
      @(posedge busclk_i); #1;
      check("t3_ungranted_wr", kb_nWR_o, 1'b1);
      host_nWR_i = 1'b1;
      check("t3_sb_empty", exp_q.size(), 0);

      // Fill the FIFO while the host holds the bus
      host_req_i = 1'b1;
      @(posedge busclk_i); #1;
      wait_gnt("t4_gnt1");
      @(posedge busclk_i); #1;
      for (int k = 0; k < 8; k++) send_evt(7'(k), 1'b1);
      check("t4_ready_full", evt_ready_o, 1'b0);
      check("t4_busy_full", busy_o, 1'b1);
      push_evt_exp(4'd0, chord_exp[0]);
      evt_valid_i = 1'b1;
      evt_key_i   = 7'd8;
      evt_down_i  = 1'b1;
      host_req_i  = 1'b0;
      #1;
      check("t4_gnt_drop", host_gnt_o, 1'b0);
      @(posedge busclk_i); #1;
      host_req_i = 1'b1;
      begin
         int n;
         n = 0;
         while (!evt_ready_o && n < 50) begin
            @(posedge busclk_i); #1;
            n++;
         end
         check("t4_ready_back", evt_ready_o, 1'b1);
      end
      @(posedge busclk_i); #1;
      evt_valid_i = 1'b0;
      wait_gnt("t4_regnt");
      check("t4_one_event_served", exp_q.size(), 0);
      check("t4_pending", busy_o, 1'b1);
      for (int k = 1; k < 9; k++) push_evt_exp((k < 8) ? 4'd0 : 4'd1, chord_exp[k]);
      @(posedge busclk_i); #1;
      host_req_i = 1'b0;
      wait_drain("t4");
      check("t4_ready_idle", evt_ready_o, 1'b1);

      // Reset in the middle of a sequence
      exp_q.push_back(rd_t(4'd6));
      send_evt(7'd50, 1'b1);
      send_evt(7'd51, 1'b1);
      begin
         int n;
         n = 0;
         while (kb_nRD_o && n < 20) begin
            @(negedge busclk_i);
            n++;
         end
      end
      check("t5_rd_row", kb_A_o, 4'd6);
      @(posedge busclk_i); #1;
      nreset_i = 1'b0;
      #1;
      check("t5_nWR", kb_nWR_o, 1'b1);
      check("t5_nRD", kb_nRD_o, 1'b1);
      check("t5_A", kb_A_o, 4'h0);
      check("t5_D", kb_D_o, 8'h00);
      check("t5_busy", busy_o, 1'b0);
      check("t5_ready", evt_ready_o, 1'b0);
      repeat (2) @(posedge busclk_i);
      #1;
      nreset_i = 1'b1;
      @(posedge busclk_i); #1;
      check("t5_ready_after", evt_ready_o, 1'b1);
      repeat (10) @(posedge busclk_i);
      #1;
      check("t5_idle", busy_o, 1'b0);
      check("t5_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
